adc_code_averager: RTL
======================

# adc_code_averager

Downstream post-processing stage for the ADC_LogiCompilation converter. It consumes the converter's 10-bit output codes with a sample strobe and accumulates a window of 2^LOG2_N samples. It then emits the rounded mean through a 4-entry output FIFO with a valid/ready handshake. It sits between the converter's io_out code bus and the user-side readout logic (Wishbone/LA capture).

## Interface
- CODE_W, 10, width of incoming ADC code and of averaged result
- LOG2_N, 4, log2 of window length; window = 2^LOG2_N samples (legal 1..8)
- FIFO_DEPTH, 4, output FIFO entries (power of two)

- wb_clk_i  in  1  single clock; all state on rising edge
- wb_rst_n  in  1  asynchronous, active-low reset
- enable_i  in  1  level; 1 = run averaging
- continuous_i  in  1  1 = back-to-back windows; 0 = one window per enable assertion
- clr_i  in  1  synchronous clear (abort window, flush FIFO, clear overflow)
- code_i  in  CODE_W  ADC code
- code_valid_i  in  1  code_i valid this cycle (no backpressure on input)
- avg_o  out  CODE_W  FIFO head result
- avg_valid_o  out  1  FIFO non-empty
- avg_ready_i  in  1  consumer accepts head when avg_valid_o=1
- busy_o  out  1  1 while in ACCUM
- overflow_o  out  1  sticky: a result was dropped on full FIFO

## Operation
- States: IDLE, ACCUM, DONE.
- IDLE: acc=0, cnt=0. enable_i=1 -> ACCUM next cycle. Samples presented in IDLE are ignored.
- ACCUM: each cycle with code_valid_i=1 adds code_i to acc (width CODE_W+LOG2_N) and increments cnt.
  - When the sample with cnt=2^LOG2_N-1 is accepted, result = (acc+code_i+2^(LOG2_N-1)) >> LOG2_N.
  - The sum is computed at CODE_W+LOG2_N+1 bits. Round-half-up. The result never exceeds 2^CODE_W-1, so no saturation logic is required.
  - The result is pushed into the FIFO on that same edge. acc and cnt clear.
  - Next state: ACCUM if continuous_i=1 and enable_i=1, else DONE.
- DONE (one-shot only): holds until enable_i=0, then IDLE. A new one-shot requires enable_i to fall and rise again.
- enable_i=0 while in ACCUM: the partial window is discarded and nothing is pushed; IDLE next cycle.
- FIFO push when full:
  - If a pop occurs in the same cycle, the push is accepted.
  - Otherwise the result is dropped and overflow_o is set.
  - The FIFO contents are unchanged.
- Pop when avg_valid_o&&avg_ready_i. Order is strictly FIFO.
- clr_i=1 has priority over everything:
  - FIFO emptied, overflow_o=0, acc/cnt=0, state IDLE.
  - The block re-enters ACCUM on the following cycle if enable_i=1.
  - A sample presented with clr_i is discarded.
- Reset values: state IDLE, avg_o=0, avg_valid_o=0, busy_o=0, overflow_o=0, FIFO pointers 0, min_o/max_o per Configuration.

## Timing
- Latency: the final window sample is accepted at edge k; avg_valid_o=1 and avg_o=result from edge k (visible in cycle k+1).
- Gapped code_valid_i is allowed; the window counts accepted samples, not cycles.
- Continuous mode has zero dead cycles between windows: a sample in the cycle right after a push counts as sample 0 of the next window.
- busy_o is registered: it is 1 from the cycle after entering ACCUM, and 0 the cycle after leaving it.
- Async reset asserted mid-window: all outputs go to reset values immediately (no clock needed). The partial window is lost.
- avg_o is stable while avg_valid_o=1 and avg_ready_i=0.

## Configuration
- ADC_AVG_MINMAX_EN defined: adds outputs min_o and max_o (CODE_W each).
  - These hold the minimum and maximum of the last completed window, updated on the push edge.
  - Dropped-overflow windows still update them.
  - Reset/clr values: min_o=2^CODE_W-1, max_o=0.
- ADC_AVG_MINMAX_EN undefined: the ports and tracking logic are absent. All other behaviour is identical.

## Test plan
- LOG2_N=4, one-shot, 16 samples of code 100 -> one result avg_o=100; busy_o falls; DONE until enable_i drops.
- Samples 0..15, one per cycle -> sum 120, (120+8)>>4 -> avg_o=8. Samples 0..14 plus 16 -> sum 121 -> avg_o=8. Sixteen samples of 1023 -> avg_o=1023.
- Continuous mode, avg_ready_i=0, 80 valid samples -> 4 results queued, 5th dropped, overflow_o=1. Pulse clr_i -> avg_valid_o=0, overflow_o=0.
- enable_i dropped after 7 samples, then re-enabled for 16 samples of 50 -> exactly one result, avg_o=50. The partial window does not contribute.
- wb_rst_n pulsed low after 9 samples -> all outputs at reset values at once. After release, 16 samples of 7 -> avg_o=7.
- ADC_AVG_MINMAX_EN: window with samples 3..18 -> min_o=3, max_o=18, avg_o=11 ((168+8)>>4).

Source files
------------

// File: rtl/adc_code_averager.sv
// Windowed mean of ADC codes (2^LOG2_N samples, round-half-up) into a small FIFO.
// Define ADC_AVG_MINMAX_EN to add per-window min_o/max_o outputs.
module adc_code_averager #(
    parameter int CODE_W     = 10,
    parameter int LOG2_N     = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n,
    input  logic              enable_i,
    input  logic              continuous_i,
    input  logic              clr_i,
    input  logic [CODE_W-1:0] code_i,
    input  logic              code_valid_i,
    output logic [CODE_W-1:0] avg_o,
    output logic              avg_valid_o,
    input  logic              avg_ready_i,
    output logic              busy_o,
    output logic              overflow_o
`ifdef ADC_AVG_MINMAX_EN
    ,
    output logic [CODE_W-1:0] min_o,
    output logic [CODE_W-1:0] max_o
`endif
);

    localparam int ACC_W = CODE_W + LOG2_N;
    localparam int SUM_W = ACC_W + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [SUM_W-1:0]  ROUND    = SUM_W'(1) << (LOG2_N - 1);
    localparam logic [LOG2_N-1:0] LAST_CNT = {LOG2_N{1'b1}};
    localparam logic [PTR_W:0]    FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [LOG2_N-1:0] cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              ovf_q, ovf_d;
    logic [PTR_W-1:0]  wr_q, wr_d;
    logic [PTR_W-1:0]  rd_q, rd_d;
    logic [PTR_W:0]    fill_q, fill_d;
    logic [CODE_W-1:0] mem_q [FIFO_DEPTH];
    logic [CODE_W-1:0] mem_d [FIFO_DEPTH];

    logic [SUM_W-1:0]  sum;
    logic [CODE_W-1:0] result;
    logic              last;
    logic              full;
    logic              pop;
    logic              push;
    logic              push_ok;

    always_comb begin
        sum    = {1'b0, acc_q} + SUM_W'(code_i) + ROUND;
        result = CODE_W'(sum >> LOG2_N);
        last   = (cnt_q == LAST_CNT);
        full   = (fill_q == FULL_CNT);
        pop    = (fill_q != '0) && avg_ready_i;
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        push    = 1'b0;
        unique case (state_q)
            IDLE: begin
                acc_d = '0;
                cnt_d = '0;
                if (enable_i) state_d = ACCUM;
            end
            ACCUM: begin
                if (!enable_i) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                end else if (code_valid_i) begin
                    if (last) begin
                        push    = 1'b1;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = continuous_i ? ACCUM : DONE;
                    end else begin
                        acc_d = acc_q + ACC_W'(code_i);
                        cnt_d = cnt_q + LOG2_N'(1);
                    end
                end
            end
            DONE: begin
                if (!enable_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (clr_i) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            push    = 1'b0;
        end
        busy_d = (state_q == ACCUM) && !clr_i;
    end

    // A push onto a full FIFO still lands if the head leaves on the same edge.
    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        fill_d  = fill_q;
        ovf_d   = ovf_q;
        push_ok = push && (!full || pop);
        if (push_ok) begin
            mem_d[wr_q] = result;
            wr_d        = wr_q + PTR_W'(1);
        end
        if (push && full && !pop) ovf_d = 1'b1;
        if (pop) rd_d = rd_q + PTR_W'(1);
        if (push_ok && !pop) begin
            fill_d = fill_q + (PTR_W + 1)'(1);
        end else if (pop && !push_ok) begin
            fill_d = fill_q - (PTR_W + 1)'(1);
        end
        if (clr_i) begin
            wr_d   = '0;
            rd_d   = '0;
            fill_d = '0;
            ovf_d  = 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            mem_q  <= '{default: '0};
            wr_q   <= '0;
            rd_q   <= '0;
            fill_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            mem_q  <= mem_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            fill_q <= fill_d;
            ovf_q  <= ovf_d;
        end
    end

    assign avg_o       = mem_q[rd_q];
    assign avg_valid_o = (fill_q != '0);
    assign busy_o      = busy_q;
    assign overflow_o  = ovf_q;

`ifdef ADC_AVG_MINMAX_EN
    localparam logic [CODE_W-1:0] CODE_MAX = {CODE_W{1'b1}};

    logic [CODE_W-1:0] wmin_q, wmin_d;
    logic [CODE_W-1:0] wmax_q, wmax_d;
    logic [CODE_W-1:0] min_q, min_d;
    logic [CODE_W-1:0] max_q, max_d;
    logic [CODE_W-1:0] smin;
    logic [CODE_W-1:0] smax;
    logic              take;

    // Running extremes of the open window; published on the push edge,
    // whether or not the FIFO had room for the mean.
    always_comb begin
        smin   = (code_i < wmin_q) ? code_i : wmin_q;
        smax   = (code_i > wmax_q) ? code_i : wmax_q;
        take   = (state_q == ACCUM) && enable_i && code_valid_i && !clr_i;
        wmin_d = wmin_q;
        wmax_d = wmax_q;
        min_d  = min_q;
        max_d  = max_q;
        if (push) begin
            min_d  = smin;
            max_d  = smax;
            wmin_d = CODE_MAX;
            wmax_d = '0;
        end else if (take) begin
            wmin_d = smin;
            wmax_d = smax;
        end else if (state_d != ACCUM || state_q != ACCUM) begin
            wmin_d = CODE_MAX;
            wmax_d = '0;
        end
        if (clr_i) begin
            wmin_d = CODE_MAX;
            wmax_d = '0;
            min_d  = CODE_MAX;
            max_d  = '0;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            wmin_q <= CODE_MAX;
            wmax_q <= '0;
            min_q  <= CODE_MAX;
            max_q  <= '0;
        end else begin
            wmin_q <= wmin_d;
            wmax_q <= wmax_d;
            min_q  <= min_d;
            max_q  <= max_d;
        end
    end

    assign min_o = min_q;
    assign max_o = max_q;
`endif

endmodule
